fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the decoder in the multi-cycle core.
- Owns the fetch PC and drives the synchronous instruction memory (one-cycle read latency).
- Buffers returned instructions with their PCs in a small prefetch FIFO.
- Presents them to decode over a valid/ready handshake; a branch/jump redirect flushes the pipe and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns fetch PC, drives IMEM, buffers words for decode
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_valid;
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_inst [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            push;
  logic            issue;

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? fifo_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight_valid & !redirect_valid;

  // Count the in-flight word as already occupying a slot so a push can never overflow.
  assign occupancy  = {1'b0, count} + (CW+1)'(inflight_valid) - (CW+1)'(pop);
  assign issue      = !redirect_valid && (occupancy < (CW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc       <= RESET_PC;
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else if (redirect_valid) begin
      fetch_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight_valid <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else begin
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      inflight_valid <= issue;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= inflight_pc;
      fifo_inst[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out, inst_pc;

  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic [31:0] w_imem_addr, w_imem_rdata;
  logic        w_inst_valid;
  logic        w_inst_ready = 1'b1;
  logic [31:0] w_inst_out, w_inst_pc;

  int vectors = 0;
  int miscompares = 0;
  int w_pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w[$];

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
    .inst_out(w_inst_out), .inst_pc(w_inst_pc)
  );

  always #5 clk = ~clk;

  // Synchronous IMEM: word(a) = a ^ KEY, one-cycle latency.
  always @(posedge clk) begin
    imem_rdata   <= imem_addr ^ KEY;
    w_imem_rdata <= w_imem_addr ^ KEY;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic restart_main(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic restart_wrap();
    exp_w.delete();
    w_pops = 0;
    for (int i = 0; i < 128; i++) exp_w.push_back(32'hFFFF_FFF8 + 32'(4 * i));
  endtask

  // Score any handshake about to complete, then advance to 1 time unit past the next edge.
  task automatic cycle();
    logic [31:0] e;
    if (inst_valid && inst_ready) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_extra: observed pop of %h expected none", inst_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst_out, e ^ KEY);
      end
    end
    if (w_inst_valid && w_inst_ready) begin
      vectors++;
      assert (exp_w.size() != 0) else begin
        miscompares++;
        $error("FAIL sbw_extra: observed pop of %h expected none", w_inst_pc);
      end
      if (exp_w.size() != 0) begin
        e = exp_w.pop_front();
        w_pops++;
        chk("sbw_pc", w_inst_pc, e);
        chk("sbw_inst", w_inst_out, e ^ KEY);
      end
    end
    vectors++;
    assert (!(dut.inflight_valid && !redirect_valid && dut.count == 2'd2 && !(inst_valid && inst_ready)))
    else begin
      miscompares++;
      $error("FAIL overflow: observed push into full fifo expected none");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    inst_ready = 1'b1;
    repeat (2) cycle();
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_out", inst_out, 32'd0);
    chk("reset_pc", inst_pc, 32'd0);
    chk("reset_addr", imem_addr, 32'd0);
    chk("reset_w_addr", w_imem_addr, 32'hFFFF_FFF8);

    // Release with decode always ready: latency and sustained throughput.
    restart_main(32'h0);
    restart_wrap();
    rst = 1'b1;
    cycle();
    chk("a_valid_lat1", 32'(inst_valid), 32'd0);
    cycle();
    chk("a_valid_lat2", 32'(inst_valid), 32'd1);
    chk("a_first_pc", inst_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("a_stream_valid", 32'(inst_valid), 32'd1);
    end
    chk("a_wrap_pops", 32'(w_pops >= 4), 32'd1);

    // Decode stalls right from the first valid instruction.
    rst = 1'b0;
    inst_ready = 1'b0;
    cycle();
    restart_main(32'h0);
    restart_wrap();
    rst = 1'b1;
    cycle();
    cycle();
    chk("b_first_valid", 32'(inst_valid), 32'd1);
    repeat (10) cycle();
    chk("b_hold_valid", 32'(inst_valid), 32'd1);
    chk("b_hold_pc", inst_pc, 32'h0);
    chk("b_hold_inst", inst_out, KEY);
    chk("b_hold_addr", imem_addr, 32'h8);
    chk("b_count", 32'(dut.count), 32'd2);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("b_drain_valid", 32'(inst_valid), 32'd1);
    end

    // Redirect with a full FIFO; target's low bits are dropped.
    inst_ready = 1'b0;
    repeat (4) cycle();
    chk("c_full", 32'(dut.count), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    cycle();
    redirect_valid = 1'b0;
    restart_main(32'h100);
    chk("c_flush_valid", 32'(inst_valid), 32'd0);
    chk("c_target_addr", imem_addr, 32'h100);
    inst_ready = 1'b1;
    cycle();
    chk("c_valid_r1", 32'(inst_valid), 32'd0);
    cycle();
    chk("c_valid_r2", 32'(inst_valid), 32'd1);
    chk("c_target_pc", inst_pc, 32'h100);
    repeat (3) cycle();

    // Back-to-back redirects while streaming; the coinciding pop still completes.
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    restart_main(32'h300);
    chk("d_flush_valid", 32'(inst_valid), 32'd0);
    chk("d_target_addr", imem_addr, 32'h300);
    cycle();
    chk("d_valid_r1", 32'(inst_valid), 32'd0);
    cycle();
    chk("d_valid_r2", 32'(inst_valid), 32'd1);
    chk("d_target_pc", inst_pc, 32'h300);
    repeat (3) cycle();

    // Asynchronous reset between edges mid-stream.
    #2;
    rst = 1'b0;
    #1;
    chk("f_async_valid", 32'(inst_valid), 32'd0);
    chk("f_async_pc", inst_pc, 32'd0);
    chk("f_async_w_valid", 32'(w_inst_valid), 32'd0);
    chk("f_async_addr", imem_addr, 32'd0);
    restart_main(32'h0);
    restart_wrap();
    cycle();
    rst = 1'b1;
    cycle();
    chk("f_valid_lat1", 32'(inst_valid), 32'd0);
    cycle();
    chk("f_valid_lat2", 32'(inst_valid), 32'd1);
    chk("f_restart_pc", inst_pc, 32'h0);
    chk("f_restart_w_pc", w_inst_pc, 32'hFFFF_FFF8);
    repeat (4) cycle();
    chk("f_wrap_pops", 32'(w_pops >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
